i2c_bus_frontend: RTL and testbench

Oversampling front end for the I2C peripheral. It synchronises and de-glitches raw SCL/SDA pads on the system clock, and detects START, STOP and repeated-START conditions. It also deserialises address/data bytes and flags the ACK slot, so the downstream peripheral state machine consumes clean single-cycle events instead of clocking directly off SCL.

---
 rtl/i2c_bus_frontend_pkg.sv | 8 +
 rtl/i2c_line_filter.sv | 30 +++
 rtl/i2c_bus_frontend.sv | 83 ++++++++
 tb/tb_i2c_bus_frontend.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/i2c_bus_frontend_pkg.sv
// i2c_bus_frontend_pkg: shared state encodings and constants for the I2C bus front end
package i2c_bus_frontend_pkg;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BITS = 2'd1;
   localparam logic [1:0] ACK  = 2'd2;
   localparam int FILTER_LEN_DEFAULT = 3;
   localparam int I2C_BITS_PER_BYTE = 8;
endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: 2-flop synchroniser plus de-glitch counter for one open-drain line
module i2c_line_filter
   import i2c_bus_frontend_pkg::*;
#(
   parameter int FILTER_LEN = FILTER_LEN_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic clean
);
   logic [1:0] sync;
   logic [3:0] cnt;
   logic [3:0] cnt_nx;
   assign cnt_nx = cnt + 4'd1;
   // Line only flips after FILTER_LEN consecutive disagreeing samples
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sync  <= 2'b11;
         cnt   <= '0;
         clean <= 1'b1;
      end else begin
         sync <= {sync[0], raw};
         if (sync[1] == clean) cnt <= '0;
         else if (cnt_nx == 4'(FILTER_LEN)) begin
            cnt   <= '0;
            clean <= sync[1];
         end else cnt <= cnt_nx;
      end
endmodule

// File: rtl/i2c_bus_frontend.sv
// i2c_bus_frontend: filtered SCL/SDA, START/STOP detection and byte/ACK deserialisation
module i2c_bus_frontend
   import i2c_bus_frontend_pkg::*;
#(
   parameter int FILTER_LEN = FILTER_LEN_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       scl_clean,
   output logic       sda_clean,
   output logic       scl_rise,
   output logic       scl_fall,
   output logic       start_det,
   output logic       stop_det,
   output logic       bus_busy,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       ack_valid,
   output logic       ack_value,
   output logic [3:0] bit_index
);
   logic       scl_q;
   logic       sda_q;
   logic       scl_hi;
   logic [1:0] state;
   logic [6:0] shreg;
   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (.clk(clk), .rst_n(rst_n), .raw(scl_in), .clean(scl_clean));
   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (.clk(clk), .rst_n(rst_n), .raw(sda_in), .clean(sda_clean));
   // SCL must be high before and after the SDA edge, so simultaneous changes never qualify
   assign scl_hi   = scl_clean & scl_q;
   assign bus_busy = state != IDLE;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         scl_q     <= 1'b1;
         sda_q     <= 1'b1;
         scl_rise  <= 1'b0;
         scl_fall  <= 1'b0;
         start_det <= 1'b0;
         stop_det  <= 1'b0;
      end else begin
         scl_q     <= scl_clean;
         sda_q     <= sda_clean;
         scl_rise  <= scl_clean & ~scl_q;
         scl_fall  <= ~scl_clean & scl_q;
         start_det <= scl_hi & sda_q & ~sda_clean;
         stop_det  <= scl_hi & ~sda_q & sda_clean;
      end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state      <= IDLE;
         bit_index  <= '0;
         shreg      <= '0;
         byte_data  <= '0;
         byte_valid <= 1'b0;
         ack_valid  <= 1'b0;
         ack_value  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         ack_valid  <= 1'b0;
         if (stop_det) begin
            state     <= IDLE;
            bit_index <= '0;
         end else if (start_det) begin
            state     <= BITS;
            bit_index <= '0;
         end else if (scl_rise && state == BITS) begin
            shreg     <= {shreg[5:0], sda_clean};
            bit_index <= bit_index + 4'd1;
            if (bit_index == 4'(I2C_BITS_PER_BYTE - 1)) begin
               byte_data  <= {shreg, sda_clean};
               byte_valid <= 1'b1;
               state      <= ACK;
            end
         end else if (scl_rise && state == ACK) begin
            ack_valid <= 1'b1;
            ack_value <= sda_clean;
            bit_index <= '0;
            state     <= BITS;
         end
      end
endmodule

// File: tb/tb_i2c_bus_frontend.sv
// tb_i2c_bus_frontend: directed scenario tests for the I2C bus front end
module tb_i2c_bus_frontend;
   localparam int H = 10;
   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       scl_in = 1'b1;
   logic       sda_in = 1'b1;
   logic       scl_clean, sda_clean, scl_rise, scl_fall, start_det, stop_det;
   logic       bus_busy, byte_valid, ack_valid, ack_value;
   logic [7:0] byte_data;
   logic [3:0] bit_index;
   int total = 0;
   int bad = 0;
   int n_rise = 0, n_fall = 0, n_start = 0, n_stop = 0, n_bv = 0, n_av = 0, width_err = 0;
   logic [7:0] last_byte = '0;
   logic       last_ack = 1'b1;
   logic [5:0] pulses;
   logic [5:0] prev_p = '0;
   always #5 clk = ~clk;
   i2c_bus_frontend #(.FILTER_LEN(3)) dut (
      .clk(clk), .rst_n(rst_n), .scl_in(scl_in), .sda_in(sda_in),
      .scl_clean(scl_clean), .sda_clean(sda_clean), .scl_rise(scl_rise), .scl_fall(scl_fall),
      .start_det(start_det), .stop_det(stop_det), .bus_busy(bus_busy), .byte_valid(byte_valid),
      .byte_data(byte_data), .ack_valid(ack_valid), .ack_value(ack_value), .bit_index(bit_index)
   );
   assign pulses = {scl_rise, scl_fall, start_det, stop_det, byte_valid, ack_valid};
   // Event monitor: counts pulses, captures data, flags any pulse wider than one cycle
   always @(negedge clk) begin
      n_rise  <= n_rise + int'(scl_rise === 1'b1);
      n_fall  <= n_fall + int'(scl_fall === 1'b1);
      n_start <= n_start + int'(start_det === 1'b1);
      n_stop  <= n_stop + int'(stop_det === 1'b1);
      n_bv    <= n_bv + int'(byte_valid === 1'b1);
      n_av    <= n_av + int'(ack_valid === 1'b1);
      if (byte_valid === 1'b1) last_byte <= byte_data;
      if (ack_valid === 1'b1) last_ack <= ack_value;
      if ((pulses & prev_p) != '0) width_err <= width_err + 1;
      prev_p <= pulses;
   end
   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic i2c_start();
      sda_in = 1'b0;
      wait_cyc(H);
      scl_in = 1'b0;
      wait_cyc(H);
   endtask
   task automatic i2c_bit(input logic b);
      sda_in = b;
      wait_cyc(H);
      scl_in = 1'b1;
      wait_cyc(H);
      scl_in = 1'b0;
      wait_cyc(H);
   endtask
   task automatic send_byte(input logic [7:0] d);
      for (int i = 7; i >= 0; i--) i2c_bit(d[i]);
   endtask
   task automatic i2c_stop();
      sda_in = 1'b0;
      wait_cyc(H);
      scl_in = 1'b1;
      wait_cyc(H);
      sda_in = 1'b1;
      wait_cyc(H);
   endtask
   task automatic test_reset();
      int s;
      #1 rst_n = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         scl_in = i[0];
         sda_in = i[1];
      end
      wait_cyc(2);
      total++; if (scl_clean !== 1'b1) begin bad++; $display("FAIL reset_scl_clean got=%b exp=1", scl_clean); end
      total++; if (sda_clean !== 1'b1) begin bad++; $display("FAIL reset_sda_clean got=%b exp=1", sda_clean); end
      total++; if (pulses !== 6'b0) begin bad++; $display("FAIL reset_pulses got=%b exp=000000", pulses); end
      total++; if (bus_busy !== 1'b0) begin bad++; $display("FAIL reset_bus_busy got=%b exp=0", bus_busy); end
      total++; if (byte_data !== 8'h00 || bit_index !== 4'd0) begin bad++; $display("FAIL reset_data got=%h/%0d exp=00/0", byte_data, bit_index); end
      scl_in = 1'b1;
      sda_in = 1'b1;
      wait_cyc(2);
      rst_n = 1'b1;
      s = n_start;
      wait_cyc(20);
      total++; if (n_start - s != 0) begin bad++; $display("FAIL release_no_start got=%0d exp=0", n_start - s); end
      total++; if (bus_busy !== 1'b0) begin bad++; $display("FAIL release_bus_busy got=%b exp=0", bus_busy); end
   endtask
   task automatic test_write_byte();
      int s_start, s_bv, s_av, lat;
      s_start = n_start; s_bv = n_bv; s_av = n_av; lat = 0;
      sda_in = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (sda_clean === 1'b0) begin lat = k; break; end
      end
      total++; if (lat != 5) begin bad++; $display("FAIL filter_latency got=%0d exp=5", lat); end
      @(negedge clk);
      total++; if (start_det !== 1'b1) begin bad++; $display("FAIL start_det_timing got=%b exp=1", start_det); end
      wait_cyc(H - 6);
      scl_in = 1'b0;
      wait_cyc(H);
      total++; if (n_start - s_start != 1) begin bad++; $display("FAIL write_start_count got=%0d exp=1", n_start - s_start); end
      total++; if (bus_busy !== 1'b1 || bit_index !== 4'd0) begin bad++; $display("FAIL write_busy_idx got=%b/%0d exp=1/0", bus_busy, bit_index); end
      send_byte(8'h54);
      total++; if (n_bv - s_bv != 1 || last_byte !== 8'h54) begin bad++; $display("FAIL write_byte got=%0d/%h exp=1/54", n_bv - s_bv, last_byte); end
      total++; if (bit_index !== 4'd8) begin bad++; $display("FAIL write_idx8 got=%0d exp=8", bit_index); end
      i2c_bit(1'b0);
      total++; if (n_av - s_av != 1 || last_ack !== 1'b0) begin bad++; $display("FAIL write_ack got=%0d/%b exp=1/0", n_av - s_av, last_ack); end
      total++; if (bit_index !== 4'd0) begin bad++; $display("FAIL write_idx0 got=%0d exp=0", bit_index); end
   endtask
   task automatic test_glitch();
      int s_r, s_f;
      i2c_bit(1'b1);
      i2c_bit(1'b0);
      sda_in = 1'b1;
      wait_cyc(H);
      scl_in = 1'b1;
      wait_cyc(H);
      s_r = n_rise; s_f = n_fall;
      scl_in = 1'b0;
      wait_cyc(2);
      scl_in = 1'b1;
      wait_cyc(H);
      total++; if (n_rise - s_r != 0 || n_fall - s_f != 0) begin bad++; $display("FAIL glitch_edges got=%0d/%0d exp=0/0", n_rise - s_r, n_fall - s_f); end
      total++; if (bit_index !== 4'd3) begin bad++; $display("FAIL glitch_idx got=%0d exp=3", bit_index); end
      scl_in = 1'b0;
      wait_cyc(H);
   endtask
   task automatic test_repeated_start();
      int s_start, s_bv, s_av;
      i2c_bit(1'b0);
      total++; if (bit_index !== 4'd4) begin bad++; $display("FAIL rs_idx4 got=%0d exp=4", bit_index); end
      s_start = n_start; s_bv = n_bv;
      sda_in = 1'b1;
      wait_cyc(H);
      scl_in = 1'b1;
      wait_cyc(H);
      i2c_start();
      total++; if (n_start - s_start != 1 || n_bv - s_bv != 0) begin bad++; $display("FAIL rs_events got=%0d/%0d exp=1/0", n_start - s_start, n_bv - s_bv); end
      total++; if (bit_index !== 4'd0 || bus_busy !== 1'b1) begin bad++; $display("FAIL rs_idx_busy got=%0d/%b exp=0/1", bit_index, bus_busy); end
      s_av = n_av;
      send_byte(8'hAB);
      total++; if (n_bv - s_bv != 1 || last_byte !== 8'hAB) begin bad++; $display("FAIL rs_byte got=%0d/%h exp=1/ab", n_bv - s_bv, last_byte); end
      i2c_bit(1'b1);
      total++; if (n_av - s_av != 1 || last_ack !== 1'b1) begin bad++; $display("FAIL rs_nack got=%0d/%b exp=1/1", n_av - s_av, last_ack); end
      i2c_stop();
   endtask
   task automatic test_two_bytes();
      int s_bv, s_stop;
      i2c_start();
      s_bv = n_bv; s_stop = n_stop;
      send_byte(8'hA5);
      total++; if (last_byte !== 8'hA5) begin bad++; $display("FAIL two_first got=%h exp=a5", last_byte); end
      i2c_bit(1'b0);
      send_byte(8'h3C);
      total++; if (n_bv - s_bv != 2 || last_byte !== 8'h3C) begin bad++; $display("FAIL two_second got=%0d/%h exp=2/3c", n_bv - s_bv, last_byte); end
      i2c_bit(1'b0);
      total++; if (bus_busy !== 1'b1) begin bad++; $display("FAIL two_busy_before got=%b exp=1", bus_busy); end
      i2c_stop();
      total++; if (n_stop - s_stop != 1) begin bad++; $display("FAIL two_stop got=%0d exp=1", n_stop - s_stop); end
      total++; if (bus_busy !== 1'b0 || bit_index !== 4'd0) begin bad++; $display("FAIL two_idle got=%b/%0d exp=0/0", bus_busy, bit_index); end
      scl_in = 1'b0;
      wait_cyc(H);
      scl_in = 1'b1;
      wait_cyc(H);
      total++; if (bit_index !== 4'd0 || n_bv - s_bv != 2) begin bad++; $display("FAIL idle_ignores_scl got=%0d/%0d exp=0/2", bit_index, n_bv - s_bv); end
   endtask
   task automatic test_simultaneous();
      int s_start, s_stop;
      s_start = n_start; s_stop = n_stop;
      scl_in = 1'b0;
      sda_in = 1'b0;
      wait_cyc(H);
      scl_in = 1'b1;
      sda_in = 1'b1;
      wait_cyc(H);
      total++; if (n_start - s_start != 0 || n_stop - s_stop != 0) begin bad++; $display("FAIL simultaneous got=%0d/%0d exp=0/0", n_start - s_start, n_stop - s_stop); end
      total++; if (bus_busy !== 1'b0) begin bad++; $display("FAIL simultaneous_busy got=%b exp=0", bus_busy); end
   endtask
   task automatic test_reset_midframe();
      int s_bv;
      i2c_start();
      i2c_bit(1'b1);
      i2c_bit(1'b0);
      i2c_bit(1'b1);
      #2 rst_n = 1'b0;
      #1;
      total++; if (bit_index !== 4'd0 || bus_busy !== 1'b0) begin bad++; $display("FAIL midframe_reset got=%0d/%b exp=0/0", bit_index, bus_busy); end
      @(negedge clk);
      rst_n = 1'b1;
      s_bv = n_bv;
      send_byte(8'h81);
      total++; if (n_bv - s_bv != 0 || bit_index !== 4'd0 || bus_busy !== 1'b0) begin bad++; $display("FAIL after_reset_ignored got=%0d/%0d/%b exp=0/0/0", n_bv - s_bv, bit_index, bus_busy); end
      scl_in = 1'b1;
      wait_cyc(H);
   endtask
   task automatic test_pulse_width();
      total++; if (width_err != 0) begin bad++; $display("FAIL pulse_width got=%0d exp=0", width_err); end
   endtask
   initial begin
      test_reset();
      test_write_byte();
      test_glitch();
      test_repeated_start();
      test_two_bytes();
      test_simultaneous();
      test_reset_midframe();
      test_pulse_width();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
